// File: rtl/pcie_rx_st_skid_fifo.sv
// RX Avalon-ST skid FIFO behind the PCIe HIP: absorbs ready-latency-2 overrun,
// presents a first-word-fall-through valid/ready stream, and flags framing/overflow.
module pcie_rx_st_skid_fifo #(
    parameter int DEPTH         = 16,
    parameter int AW            = 4,
    parameter int READY_LATENCY = 2
) (
    input  logic          pld_clk,
    input  logic          srstn,
    input  logic          rx_st_valid0,
    input  logic          rx_st_sop0,
    input  logic          rx_st_eop0,
    input  logic          rx_st_err0,
    input  logic [63:0]   rx_st_data0,
    input  logic [7:0]    rx_st_be0,
    input  logic [7:0]    rx_st_bardec0,
    output logic          rx_st_ready0,
    output logic          app_rx_valid,
    input  logic          app_rx_ready,
    output logic [63:0]   app_rx_data,
    output logic [7:0]    app_rx_be,
    output logic [7:0]    app_rx_bardec,
    output logic          app_rx_sop,
    output logic          app_rx_eop,
    output logic          app_rx_err,
    output logic [AW:0]   fill_level,
    output logic          tlp_avail,
    output logic          overflow,
    output logic          frame_err
);

    localparam int          EW        = 83;
    localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - READY_LATENCY - 2);
    localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [EW-1:0] ram [DEPTH];
    logic [EW-1:0] head_reg;
    logic [EW-1:0] wr_entry;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic [AW:0]   eop_cnt_reg;
    logic [AW:0]   eop_cnt_next;
    logic          ready_reg;
    logic          in_tlp_reg;
    logic          overflow_reg;
    logic          frame_err_reg;
    logic          full;
    logic          push;
    logic          pop;
    logic          push_eop;
    logic          pop_eop;
    logic          frame_bad;

    assign wr_entry = {rx_st_err0, rx_st_eop0, rx_st_sop0, rx_st_bardec0, rx_st_be0, rx_st_data0};

    assign full         = (count_reg == FULL_LVL);
    assign app_rx_valid = (count_reg != '0);
    assign pop          = app_rx_valid & app_rx_ready;
    // A pop at full frees the head slot in the same cycle, so the beat is still accepted.
    assign push         = rx_st_valid0 & (~full | pop);
    assign push_eop     = push & rx_st_eop0;
    assign pop_eop      = pop & app_rx_eop;
    assign frame_bad    = rx_st_sop0 ? in_tlp_reg : ~in_tlp_reg;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        if (pop)
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end

    always_comb begin
        count_next = count_reg;
        if (push & ~pop)
            count_next = count_reg + CNT_ONE;
        else if (pop & ~push)
            count_next = count_reg - CNT_ONE;
    end

    always_comb begin
        eop_cnt_next = eop_cnt_reg;
        if (push_eop & ~pop_eop)
            eop_cnt_next = eop_cnt_reg + CNT_ONE;
        else if (pop_eop & ~push_eop)
            eop_cnt_next = eop_cnt_reg - CNT_ONE;
    end

    always_ff @(posedge pld_clk) begin
        if (push)
            ram[wr_ptr_reg] <= wr_entry;
    end

    // Registered head slot; bypass covers a write into the slot that becomes the head.
    always_ff @(posedge pld_clk) begin
        if (push && (wr_ptr_reg == rd_ptr_next))
            head_reg <= wr_entry;
        else
            head_reg <= ram[rd_ptr_next];
    end

    always_ff @(posedge pld_clk or negedge srstn) begin
        if (!srstn) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            eop_cnt_reg   <= '0;
            ready_reg     <= 1'b0;
            in_tlp_reg    <= 1'b0;
            overflow_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            eop_cnt_reg <= eop_cnt_next;
            ready_reg   <= (count_next <= READY_MAX);
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                if (rx_st_eop0)
                    in_tlp_reg <= 1'b0;
                else if (rx_st_sop0)
                    in_tlp_reg <= 1'b1;
                if (frame_bad)
                    frame_err_reg <= 1'b1;
            end
            if (rx_st_valid0 & ~push)
                overflow_reg <= 1'b1;
        end
    end

    assign rx_st_ready0  = ready_reg;
    assign fill_level    = count_reg;
    assign tlp_avail     = (eop_cnt_reg != '0);
    assign overflow      = overflow_reg;
    assign frame_err     = frame_err_reg;
    assign app_rx_data   = head_reg[63:0];
    assign app_rx_be     = head_reg[71:64];
    assign app_rx_bardec = head_reg[79:72];
    assign app_rx_sop    = head_reg[80];
    assign app_rx_eop    = head_reg[81];
    assign app_rx_err    = head_reg[82];

endmodule
